// File: rtl/tipi_msg_sync.sv
// tipi_msg_sync: TI latch sampler, debounce filter, toggle decoder and byte FIFO.
// Optional TIPI_MSG_COUNT_EN adds a 16-bit pushed-byte counter output.
module tipi_msg_sync #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          STABLE_CYC = 4,
  parameter logic [6:0]  CMD_DATA   = 7'h01,
  parameter logic [6:0]  CMD_RESET  = 7'h7F
) (
  input  logic                          clk,
  input  logic                          ti_reset,
  input  logic [7:0]                    rpi_d,
  input  logic [7:0]                    rpi_s,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    ack_byte,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
`ifdef TIPI_MSG_COUNT_EN
  ,
  output logic [15:0]                   byte_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STABLE_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    PUSH,
    FULL_WAIT,
    FLUSH
  } state_t;

  state_t state, state_n;

  logic [7:0]    d1, d2, s1, s2;
  logic [7:0]    sd, ss;
  logic [CW-1:0] cnt;
  logic          same;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          full, empty;
  logic          push, pop, flush;
  logic          ack_ld;
  logic          is_data, is_rst;

  assign same    = ({d1, s1} == {d2, s2});
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign m_valid = !empty;
  assign m_data  = mem[rd_ptr[AW-1:0]];
  assign push    = (state == PUSH);
  assign flush   = (state == FLUSH);
  assign pop     = m_valid && m_ready && !flush;
  assign is_data = (ss[7:1] == CMD_DATA);
  assign is_rst  = (ss[7:1] == CMD_RESET);
  assign busy    = (state != IDLE);
  assign fifo_level = wr_ptr - rd_ptr;

  // Two-flop sync, stability counter and stable copy (frozen while busy)
  always_ff @(posedge clk or negedge ti_reset) begin
    if (!ti_reset) begin
      d1  <= '0;
      d2  <= '0;
      s1  <= '0;
      s2  <= '0;
      sd  <= '0;
      ss  <= '0;
      cnt <= '0;
    end else begin
      d1 <= rpi_d;
      d2 <= d1;
      s1 <= rpi_s;
      s2 <= s1;
      if (!same)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYC - 1))
        cnt <= cnt + 1'b1;
      if (state == IDLE && same &&
          cnt >= CW'(STABLE_CYC - 2)) begin
        sd <= d2;
        ss <= s2;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge ti_reset) begin
    if (!ti_reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state and ack-load decode
  always_comb begin
    state_n = state;
    ack_ld  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss[0] != ack_byte[0])
          state_n = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_data: state_n = (!full || pop) ? PUSH : FULL_WAIT;
          is_rst:  state_n = FLUSH;
          default: begin
            ack_ld  = 1'b1;
            state_n = IDLE;
          end
        endcase
      end
      PUSH: begin
        ack_ld  = 1'b1;
        state_n = IDLE;
      end
      FULL_WAIT: begin
        if (!full || pop)
          state_n = PUSH;
      end
      FLUSH: begin
        ack_ld  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO pointers and ack echo; flush overrides a same-cycle pop
  always_ff @(posedge clk or negedge ti_reset) begin
    if (!ti_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ack_byte <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (flush)
        rd_ptr <= wr_ptr;
      else if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (ack_ld)
        ack_byte <= ss;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= sd;
  end

`ifdef TIPI_MSG_COUNT_EN
  // Pushed-byte counter, cleared by flush
  always_ff @(posedge clk or negedge ti_reset) begin
    if (!ti_reset)
      byte_count <= '0;
    else if (flush)
      byte_count <= '0;
    else if (push)
      byte_count <= byte_count + 16'd1;
  end
`endif

endmodule
